// File: rtl/video_dram_fetch_if.sv
// Video-port bus between the fetch block (master) and the DRAM arbiter (slave).
interface video_dram_fetch_if;
  logic        dram_req;
  logic [20:0] dram_addr;
  logic        dram_ack;
  logic        dram_rdy;
  logic [15:0] dram_rdata;

  modport master (
    output dram_req,
    output dram_addr,
    input  dram_ack,
    input  dram_rdy,
    input  dram_rdata
  );

  modport slave (
    input  dram_req,
    input  dram_addr,
    output dram_ack,
    output dram_rdy,
    output dram_rdata
  );
endinterface

// File: rtl/video_dram_fetch.sv
// Paces video DRAM reads from the mode decoder's address/bandwidth budget and
// buffers the returned words in a small FIFO drained by the renderer.
module video_dram_fetch #(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      line_start_s,
  input  logic                      video_go,
  input  logic                      dram_slot,
  input  logic [4:0]                video_bw,
  input  logic [20:0]               video_addr,
  output logic                      video_next,
  video_dram_fetch_if.master        dram,
  input  logic                      fetch_stb,
  output logic [15:0]               vdata,
  output logic                      vdata_vld,
  output logic                      underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [2:0]      slot;
  logic [2:0]      used;
  logic [2:0]      need;
  logic [2:0]      win_last;

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_idx;
  logic [CW-1:0]   count;
  logic [CW:0]     fill;

  logic            outstanding;
  logic            credit_ok;
  logic            budget;
  logic            issue;
  logic            push;
  logic            do_pop;
  logic            slot_wrap;

  // Illegal encodings fall back to the most conservative budget: 1 read per 8 slots.
  always_comb begin
    need     = 3'd1;
    win_last = 3'd7;
    case (video_bw[2:0])
      3'b010:  need = 3'd2;
      3'b100:  need = 3'd4;
      default: need = 3'd1;
    endcase
    case (video_bw[4:3])
      2'b00:   win_last = 3'd1;
      2'b01:   win_last = 3'd3;
      default: win_last = 3'd7;
    endcase
  end

  assign outstanding = (state != IDLE);
  assign fill        = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign credit_ok   = (fill < (CW+1)'(DEPTH));
  assign budget      = video_go && (used < need) && credit_ok;
  assign issue       = rst_n && (state == IDLE) && dram_slot && budget;
  assign slot_wrap   = video_go && dram_slot && (slot >= win_last);

  assign vdata_vld   = (count != '0);
  assign vdata       = mem[rd_ptr];
  assign do_pop      = fetch_stb && vdata_vld;
  assign wr_idx      = line_start_s ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    video_next    = 1'b0;
    dram.dram_req = 1'b0;
    push          = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt  = REQ;
          video_next = 1'b1;
        end
      end
      REQ: begin
        dram.dram_req = 1'b1;
        if (dram.dram_ack) state_nxt = WAIT;
      end
      WAIT: begin
        if (dram.dram_rdy) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dram.dram_addr <= '0;
    end else if (issue) begin
      dram.dram_addr <= video_addr;
    end
  end

  // A window wrap clears the read count even if a read issues on the same slot.
  always_ff @(posedge clk) begin
    if (!rst_n || line_start_s) begin
      slot <= '0;
      used <= '0;
    end else begin
      if (!video_go) begin
        slot <= '0;
      end else if (dram_slot) begin
        slot <= slot_wrap ? 3'd0 : slot + 3'd1;
      end
      if (slot_wrap) begin
        used <= '0;
      end else if (issue) begin
        used <= used + 3'd1;
      end
    end
  end

  // A flush still accepts a word arriving on the same clock into the emptied FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      underrun <= 1'b0;
    end else begin
      if (fetch_stb && !vdata_vld) underrun <= 1'b1;
      if (push) mem[wr_idx] <= dram.dram_rdata;
      if (line_start_s) begin
        wr_ptr <= AW'(push);
        rd_ptr <= '0;
        count  <= CW'(push);
      end else begin
        if (push)   wr_ptr <= wr_ptr + AW'(1);
        if (do_pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(do_pop);
      end
    end
  end

endmodule

// File: tb/tb_video_dram_fetch.sv
// Directed bench for video_dram_fetch with a small auto-responding arbiter model.
module tb_video_dram_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start_s;
  logic        video_go;
  logic        dram_slot;
  logic [4:0]  video_bw;
  logic [20:0] video_addr;
  logic        video_next;
  logic        fetch_stb;
  logic [15:0] vdata;
  logic        vdata_vld;
  logic        underrun;

  logic [20:0] addr_base;
  int          col = 0;
  int          col0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mask;

  logic        ack_auto = 1'b0;
  logic        rdy_auto = 1'b0;
  logic        ack_man  = 1'b0;
  logic        rdy_man  = 1'b0;
  logic [15:0] man_data = '0;
  logic [15:0] rdy_word = '0;
  logic        hold_ack = 1'b0;
  logic        hold_rdy = 1'b0;
  int          req_age  = 0;
  int          rdy_timer = 0;

  video_dram_fetch_if dram_bus ();

  video_dram_fetch #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_start_s (line_start_s),
    .video_go     (video_go),
    .dram_slot    (dram_slot),
    .video_bw     (video_bw),
    .video_addr   (video_addr),
    .video_next   (video_next),
    .dram         (dram_bus),
    .fetch_stb    (fetch_stb),
    .vdata        (vdata),
    .vdata_vld    (vdata_vld),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  assign video_addr          = addr_base + 21'(col);
  assign dram_bus.dram_ack   = ack_auto | ack_man;
  assign dram_bus.dram_rdy   = rdy_auto | rdy_man;
  assign dram_bus.dram_rdata = rdy_man ? man_data : rdy_word;

  // Column counter the mode decoder would advance on each accepted address.
  always @(posedge clk) if (video_next) col <= col + 1;

  // Arbiter model: ack one clk after seeing a request, data two clks after the ack.
  always @(posedge clk) begin
    #1;
    ack_auto = 1'b0;
    rdy_auto = 1'b0;
    if (hold_rdy) rdy_timer = 0;
    else if (rdy_timer == 1) begin
      rdy_auto  = 1'b1;
      rdy_timer = 0;
    end else if (rdy_timer > 1) rdy_timer--;
    if (!dram_bus.dram_req) req_age = 0;
    else if (!hold_ack) begin
      if (req_age == 1) begin
        ack_auto  = 1'b1;
        req_age   = 0;
        rdy_timer = 2;
        rdy_word  = dram_bus.dram_addr[15:0] ^ 16'h5A5A;
      end else req_age++;
    end
  end

  function automatic logic [15:0] wordAt(input int k);
    logic [20:0] a;
    a = addr_base + 21'(k);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int n, input int gap, output logic [31:0] m);
    m = '0;
    tick();
    for (int i = 0; i < n; i++) begin
      dram_slot = 1'b1;
      @(negedge clk);
      m[i] = video_next;
      tick();
      dram_slot = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic popOne();
    tick();
    fetch_stb = 1'b1;
    tick();
    fetch_stb = 1'b0;
  endtask

  task automatic flushLine();
    tick();
    video_go     = 1'b0;
    line_start_s = 1'b1;
    tick();
    line_start_s = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: bench did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; line_start_s = 1'b0; video_go = 1'b0; dram_slot = 1'b0;
    video_bw = 5'b11001; fetch_stb = 1'b0; addr_base = 21'h01000;
    repeat (3) tick();
    settle();
    checkOutput("rst_video_next", 32'(video_next), 32'd0);
    checkOutput("rst_dram_req", 32'(dram_bus.dram_req), 32'd0);
    checkOutput("rst_dram_addr", 32'(dram_bus.dram_addr), 32'd0);
    checkOutput("rst_vdata", 32'(vdata), 32'd0);
    checkOutput("rst_vdata_vld", 32'(vdata_vld), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    tick();
    rst_n = 1'b1;

    // 8-slot window, one read per window.
    video_bw = 5'b11001; video_go = 1'b1; col0 = col;
    applyStimulus(16, 8, mask);
    settle();
    checkOutput("zx_issue_mask", mask, 32'h0101);
    checkOutput("zx_count", 32'(dut.count), 32'd2);
    checkOutput("zx_head", 32'(vdata), 32'(wordAt(col0)));
    checkOutput("zx_last_addr", 32'(dram_bus.dram_addr), 32'(addr_base + 21'(col0 + 1)));

    // Four reads early in the window, nothing later.
    flushLine();
    video_bw = 5'b11100; video_go = 1'b1; col0 = col;
    applyStimulus(8, 8, mask);
    settle();
    checkOutput("text_issue_mask", mask, 32'h000F);
    checkOutput("text_count", 32'(dut.count), 32'd4);
    checkOutput("text_slot_wrap", 32'(dut.slot), 32'd0);
    checkOutput("text_head", 32'(vdata), 32'(wordAt(col0)));
    popOne();
    settle();
    checkOutput("text_pop_head", 32'(vdata), 32'(wordAt(col0 + 1)));
    checkOutput("text_pop_count", 32'(dut.count), 32'd3);

    // Credit exhaustion at a full FIFO, then exactly one refill after a pop.
    flushLine();
    video_bw = 5'b00001; video_go = 1'b1;
    applyStimulus(24, 8, mask);
    settle();
    checkOutput("fill_issue_mask", mask, 32'h5555);
    checkOutput("fill_count", 32'(dut.count), 32'd8);
    popOne();
    applyStimulus(4, 8, mask);
    settle();
    checkOutput("refill_issue_mask", mask, 32'h0001);
    checkOutput("refill_count", 32'(dut.count), 32'd8);

    // Simultaneous push and pop at count 3.
    flushLine();
    video_bw = 5'b11100; video_go = 1'b1; col0 = col;
    applyStimulus(3, 8, mask);
    settle();
    checkOutput("pp_pre_count", 32'(dut.count), 32'd3);
    hold_rdy = 1'b1;
    applyStimulus(1, 6, mask);
    tick();
    rdy_man = 1'b1; man_data = 16'hBEEF; fetch_stb = 1'b1;
    tick();
    rdy_man = 1'b0; fetch_stb = 1'b0; hold_rdy = 1'b0;
    settle();
    checkOutput("pp_count", 32'(dut.count), 32'd3);
    checkOutput("pp_head", 32'(vdata), 32'(wordAt(col0 + 1)));
    popOne();
    popOne();
    settle();
    checkOutput("pp_pushed_word", 32'(vdata), 32'hBEEF);

    // Flush while a read is in flight; the late word lands in the empty FIFO.
    flushLine();
    video_bw = 5'b00001; video_go = 1'b1;
    applyStimulus(10, 8, mask);
    hold_rdy = 1'b1;
    applyStimulus(1, 6, mask);
    settle();
    checkOutput("ls_pre_count", 32'(dut.count), 32'd5);
    checkOutput("ls_pre_used", 32'(dut.used), 32'd1);
    tick();
    line_start_s = 1'b1;
    tick();
    line_start_s = 1'b0;
    settle();
    checkOutput("ls_count", 32'(dut.count), 32'd0);
    checkOutput("ls_slot", 32'(dut.slot), 32'd0);
    checkOutput("ls_used", 32'(dut.used), 32'd0);
    checkOutput("ls_vld", 32'(vdata_vld), 32'd0);
    tick();
    rdy_man = 1'b1; man_data = 16'h1234;
    tick();
    rdy_man = 1'b0; hold_rdy = 1'b0;
    settle();
    checkOutput("ls_late_count", 32'(dut.count), 32'd1);
    checkOutput("ls_late_word", 32'(vdata), 32'h1234);

    // Underrun is sticky; reset in REQ drops the request and clears outputs.
    checkOutput("ur_before", 32'(underrun), 32'd0);
    popOne();
    popOne();
    settle();
    checkOutput("ur_set", 32'(underrun), 32'd1);
    repeat (3) tick();
    settle();
    checkOutput("ur_sticky", 32'(underrun), 32'd1);
    hold_ack = 1'b1;
    applyStimulus(1, 4, mask);
    settle();
    checkOutput("rq_req_high", 32'(dram_bus.dram_req), 32'd1);
    tick();
    rst_n = 1'b0; dram_slot = 1'b1;
    tick();
    settle();
    checkOutput("rq_rst_req", 32'(dram_bus.dram_req), 32'd0);
    checkOutput("rq_rst_next", 32'(video_next), 32'd0);
    checkOutput("rq_rst_addr", 32'(dram_bus.dram_addr), 32'd0);
    checkOutput("rq_rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rq_rst_vld", 32'(vdata_vld), 32'd0);
    tick();
    dram_slot = 1'b0; video_go = 1'b0; hold_ack = 1'b0; rst_n = 1'b1;
    tick();
    rdy_man = 1'b1; man_data = 16'hDEAD;
    tick();
    rdy_man = 1'b0;
    settle();
    checkOutput("rq_late_rdy_ignored", 32'(vdata_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
